alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
- Decode/issue stage that feeds the ALU.
- Accepts a 32-bit RV32I instruction and PC over a valid/ready handshake.
- Decodes the instruction into the ALU's control fields (ALUctrl, ALUsrc, ImmOp), register specifiers and writeback/branch flags.
- Holds the results in a registered ID/EX boundary with backpressure and flush.

Parameters:
- WIDTH, 32, datapath width; >= 32; immediates sign-extended to WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  stage can accept.
- in_instr  input  32  instruction word.
- in_pc  input  WIDTH  instruction PC.
- flush  input  1  kill held/incoming instruction.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  ALU stage accepts bundle.
- out_pc  output  WIDTH  registered PC.
- out_rs1, out_rs2, out_rd  output  5 each  register specifiers.
- ALUctrl  output  4  ALU operation.
- ALUsrc  output  1  1 = ImmOp as operand 2.
- ImmOp  output  WIDTH  sign-extended immediate.
- op1_sel  output  2  00 = rs1, 01 = PC, 10 = zero.
- reg_write, mem_read, mem_write, branch, jump  output  1 each.
- illegal  output  1  unsupported encoding.

Behaviour:
Reset and latency:
- Reset (async assert, sync release): every output 0; in_ready = 1 once out_valid = 0.
- Latency is 1 cycle: accepted in cycle N (in_valid & in_ready), out_valid = 1 in cycle N+1.

Handshake:
- Bundle held stable while out_valid & ~out_ready.
- in_ready = ~out_valid | out_ready.
- Simultaneous consume and accept: new bundle replaces old, out_valid stays 1, no bubble.

ALUctrl encoding:
- 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.

Decode table:
- OP (0110011): funct3 000 → ADD if funct7 = 0000000, SUB if 0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 → SRL if funct7 = 0000000, SRA if 0100000; 110 OR; 111 AND.
  - Any other funct7 → illegal.
  - ALUsrc = 0, reg_write = 1.
- OP-IMM (0010011): same funct3 map, I-immediate, no SUB.
  - 001 requires imm[11:5] = 0000000.
  - 101 requires imm[11:5] = 0000000 (SRL) or 0100000 (SRA); else illegal.
  - ALUsrc = 1, reg_write = 1.
- LOAD (0000011): ADD, I-imm, ALUsrc = 1, mem_read = 1, reg_write = 1.
- STORE (0100011): ADD, S-imm, ALUsrc = 1, mem_write = 1.
- BRANCH (1100011): B-imm, ALUsrc = 0, branch = 1.
  - funct3 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU; 010/011 → illegal.
- LUI (0110111): ADD, op1_sel = 10, U-imm, ALUsrc = 1, reg_write = 1.
- AUIPC (0010111): ADD, op1_sel = 01, U-imm, ALUsrc = 1, reg_write = 1.
- JAL (1101111): ADD, op1_sel = 01, J-imm, ALUsrc = 1, jump = 1, reg_write = 1.
- JALR (1100111, funct3 000): ADD, I-imm, ALUsrc = 1, jump = 1, reg_write = 1.
- Any other opcode/funct3: illegal = 1; ALUctrl, ALUsrc, op1_sel and all write/branch/jump flags forced 0. out_valid still asserted so the exception propagates.
- rs1/rs2/rd are always the raw fields [19:15]/[24:20]/[11:7].

Flush:
- flush = 1 clears out_valid next edge, overriding any acceptance that cycle; the instruction accepted that cycle is discarded.
- in_ready is not gated by flush.
- Flush with no valid bundle has no effect.

Reset mid-operation:
- Held bundle lost, out_valid = 0 immediately (asynchronous).

Optional Feature:
- Macro: ALU_DEC_SKID_EN.
- Defined:
  - A 1-entry skid buffer behind the output register; in_ready is registered (= skid empty).
  - An instruction accepted while the output is stalled goes to skid.
  - Skid drains into the output register on the first out_ready cycle.
  - Order is preserved; flush clears both entries.
- Undefined: no skid, combinational in_ready as above.

Test Plan:
- 0x002081B3 (add x3,x1,x2) then 0x402081B3, out_ready = 1 → ALUctrl 0000 then 0001, ALUsrc 0, rs1 1, rs2 2, rd 3, reg_write 1, each 1 cycle after accept.
- 0xFFF00293 (addi x5,x0,-1) → ImmOp 0xFFFFFFFF, ALUsrc 1, rd 5. 0x4030D093 (srai x1,x1,3) → ALUctrl 0111, ImmOp 0x00000403.
- 0xFE208EE3 (beq x1,x2,-4), PC 0x100 → ALUctrl 0001, ImmOp 0xFFFFFFFC, branch 1, out_pc 0x100. 0xFFFFFFFF → illegal 1, reg_write 0.
- Backpressure: out_ready = 0 for 3 cycles, 2 instructions offered.
  - Without skid: bundle stable, in_ready 0, second accepted on the out_ready cycle.
  - With ALU_DEC_SKID_EN: second accepted, delivered in order.
- Flush while out_valid = 1 and new accept in the same cycle → next cycle out_valid 0, no bundle appears. rst_n low mid-stall → out_valid 0 asynchronously; in_ready 1 after release.

Source files
------------

// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage: instruction -> ALU control bundle, held in a registered ID/EX boundary.
// Optional macro ALU_DEC_SKID_EN adds a 1-entry skid buffer and a registered in_ready.
module alu_decode_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [3:0]       ALUctrl,
  output logic             ALUsrc,
  output logic [WIDTH-1:0] ImmOp,
  output logic [1:0]       op1_sel,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             jump,
  output logic             illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [3:0]       alu_ctrl;
    logic             alu_src;
    logic [WIDTH-1:0] imm;
    logic [1:0]       op1_sel;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             illegal;
  } bundle_t;

  function automatic logic [3:0] alu_of_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = WIDTH'($signed(in_instr[31:20]));
  assign imm_s = WIDTH'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = WIDTH'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = WIDTH'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = WIDTH'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  bundle_t dec;
  logic    legal;

  // ImmOp is zero whenever the instruction carries no immediate (R-type, illegal).
  always_comb begin
    dec       = '0;
    legal     = 1'b1;
    dec.pc    = in_pc;
    dec.rs1   = in_instr[19:15];
    dec.rs2   = in_instr[24:20];
    dec.rd    = in_instr[11:7];
    case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (funct7 == F7_ZERO)
          dec.alu_ctrl = alu_of_f3(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000)
          dec.alu_ctrl = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)
          dec.alu_ctrl = ALU_SRA;
        else
          legal = 1'b0;
      end
      OPC_OPIMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_i;
        dec.alu_ctrl  = alu_of_f3(funct3);
        if (funct3 == 3'b001 && funct7 != F7_ZERO)
          legal = 1'b0;
        if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)
            dec.alu_ctrl = ALU_SRA;
          else if (funct7 != F7_ZERO)
            legal = 1'b0;
        end
      end
      OPC_LOAD: begin
        dec.alu_src   = 1'b1;
        dec.imm       = imm_i;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_src   = 1'b1;
        dec.imm       = imm_s;
        dec.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm    = imm_b;
        dec.branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec.alu_ctrl = ALU_SUB;
          3'b100, 3'b101: dec.alu_ctrl = ALU_SLT;
          3'b110, 3'b111: dec.alu_ctrl = ALU_SLTU;
          default:        legal        = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec.op1_sel   = 2'b10;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1_sel   = 2'b01;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec.op1_sel   = 2'b01;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_j;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          dec.alu_src   = 1'b1;
          dec.imm       = imm_i;
          dec.jump      = 1'b1;
          dec.reg_write = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    // Illegal encodings still travel down the pipe, but with every side effect stripped.
    if (!legal) begin
      dec.alu_ctrl  = ALU_ADD;
      dec.alu_src   = 1'b0;
      dec.imm       = '0;
      dec.op1_sel   = 2'b00;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.illegal   = 1'b1;
    end
  end

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and a held bundle stays stable until it transfers.
  bundle_t ob;
  logic    out_valid_q;
  logic    accept;

  assign accept = in_valid & in_ready;

`ifdef ALU_DEC_SKID_EN
  bundle_t skid;
  logic    skid_valid;
  logic    out_adv;

  assign in_ready = ~skid_valid;
  assign out_adv  = ~out_valid_q | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ob          <= '0;
      skid_valid  <= 1'b0;
      skid        <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (out_adv) begin
      // The skid entry is older than anything offered now, so it drains first.
      if (skid_valid) begin
        ob          <= skid;
        out_valid_q <= 1'b1;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        ob          <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid       <= dec;
      skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = ~out_valid_q | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ob          <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      ob          <= dec;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_pc    = ob.pc;
  assign out_rs1   = ob.rs1;
  assign out_rs2   = ob.rs2;
  assign out_rd    = ob.rd;
  assign ALUctrl   = ob.alu_ctrl;
  assign ALUsrc    = ob.alu_src;
  assign ImmOp     = ob.imm;
  assign op1_sel   = ob.op1_sel;
  assign reg_write = ob.reg_write;
  assign mem_read  = ob.mem_read;
  assign mem_write = ob.mem_write;
  assign branch    = ob.branch;
  assign jump      = ob.jump;
  assign illegal   = ob.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed test-plan steps, then a random stream
// scored against a queue-based reference model of the decode rules and the handshake.
module tb_alu_decode_stage;
  localparam int W  = 32;
  localparam int BW = 2 * W + 28;

`ifdef ALU_DEC_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam int              F3_OP [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  localparam logic [6:0]      OPCS  [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                            7'h37, 7'h17, 7'h6F, 7'h67};

  logic          clk, rst_n;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]   in_instr;
  logic [W-1:0]  in_pc, out_pc, ImmOp;
  logic [4:0]    out_rs1, out_rs2, out_rd;
  logic [3:0]    ALUctrl;
  logic [1:0]    op1_sel;
  logic          ALUsrc, reg_write, mem_read, mem_write, branch, jump, illegal;
  logic [BW-1:0] dut_b;

  alu_decode_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmOp(ImmOp),
    .op1_sel(op1_sel), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .illegal(illegal)
  );

  assign dut_b = {out_pc, out_rs1, out_rs2, out_rd, ALUctrl, ALUsrc, ImmOp, op1_sel,
                  reg_write, mem_read, mem_write, branch, jump, illegal};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode: immediates rebuilt arithmetically from instruction bit weights.
  function automatic logic [BW-1:0] ref_decode(input logic [31:0] ins, input logic [W-1:0] pc);
    int opc = int'(ins[6:0]);
    int f3  = int'(ins[14:12]);
    int f7  = int'(ins[31:25]);
    int alu = 0, sel = 0, imm = 0;
    int src = 0, rw = 0, mr = 0, mw = 0, br = 0, jp = 0, bad = 0;
    int i_imm = int'($signed(ins[31:20]));
    int s_imm = int'($signed({ins[31:25], ins[11:7]}));
    int b_imm = (ins[31] ? -4096 : 0) + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
    int u_imm = ins[31:12] * 4096;
    int j_imm = (ins[31] ? -(1 << 20) : 0) + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
    case (opc)
      'h33: begin
        rw = 1;
        if (f7 == 0) alu = F3_OP[f3];
        else if (f7 == 32 && f3 == 0) alu = 1;
        else if (f7 == 32 && f3 == 5) alu = 7;
        else bad = 1;
      end
      'h13: begin
        rw = 1; src = 1; imm = i_imm; alu = F3_OP[f3];
        if (f3 == 1 && f7 != 0) bad = 1;
        if (f3 == 5 && f7 == 32) alu = 7;
        if (f3 == 5 && f7 != 32 && f7 != 0) bad = 1;
      end
      'h03: begin src = 1; imm = i_imm; mr = 1; rw = 1; end
      'h23: begin src = 1; imm = s_imm; mw = 1; end
      'h63: begin
        br = 1; imm = b_imm;
        if (f3 == 2 || f3 == 3) bad = 1;
        else alu = (f3 < 2) ? 1 : (f3 < 6) ? 3 : 4;
      end
      'h37: begin sel = 2; src = 1; imm = u_imm; rw = 1; end
      'h17: begin sel = 1; src = 1; imm = u_imm; rw = 1; end
      'h6F: begin sel = 1; src = 1; imm = j_imm; jp = 1; rw = 1; end
      'h67: begin
        if (f3 == 0) begin src = 1; imm = i_imm; jp = 1; rw = 1; end
        else bad = 1;
      end
      default: bad = 1;
    endcase
    if (bad != 0) begin
      alu = 0; sel = 0; imm = 0; src = 0; rw = 0; mr = 0; mw = 0; br = 0; jp = 0;
    end
    return {pc, ins[19:15], ins[24:20], ins[11:7], alu[3:0], src[0], imm[W-1:0], sel[1:0],
            rw[0], mr[0], mw[0], br[0], jp[0], bad[0]};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] opc;
    logic [6:0] f7;
    int k = $urandom_range(0, 10);
    opc = (k < 9) ? OPCS[k] : 7'($urandom);
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  // driver: one clock cycle; outputs are scored against the model, then the model advances.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [W-1:0] pc,
                       input logic ordy, input logic fl, output bit acc);
    bit exp_rdy, cons;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || ordy);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("bundle", dut_b, exp_q[0]);
    check("in_ready", in_ready, exp_rdy);
    cons = (exp_q.size() != 0) && ordy;
    acc  = v && exp_rdy;
    if (fl) exp_q.delete();
    else begin
      if (cons) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_decode(ins, pc));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          acc;
    int          idx;
    logic [31:0] bp_ins [2];
    logic        cur_v;
    logic [31:0] cur_i;
    logic [W-1:0] cur_pc;

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_bundle", dut_b, '0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // R-type add / sub
    cycle(1'b1, 32'h002081B3, 32'h0, 1'b1, 1'b0, acc);
    check("add_alu", ALUctrl, 4'b0000);
    check("add_src", ALUsrc, 1'b0);
    check("add_rs1", out_rs1, 5'd1);
    check("add_rs2", out_rs2, 5'd2);
    check("add_rd", out_rd, 5'd3);
    check("add_rw", reg_write, 1'b1);
    cycle(1'b1, 32'h402081B3, 32'h4, 1'b1, 1'b0, acc);
    check("sub_alu", ALUctrl, 4'b0001);
    check("sub_valid", out_valid, 1'b1);

    // I-type
    cycle(1'b1, 32'hFFF00293, 32'h8, 1'b1, 1'b0, acc);
    check("addi_imm", ImmOp, 32'hFFFFFFFF);
    check("addi_src", ALUsrc, 1'b1);
    check("addi_rd", out_rd, 5'd5);
    cycle(1'b1, 32'h4030D093, 32'hC, 1'b1, 1'b0, acc);
    check("srai_alu", ALUctrl, 4'b0111);
    check("srai_imm", ImmOp, 32'h00000403);

    // branch and illegal
    cycle(1'b1, 32'hFE208EE3, 32'h100, 1'b1, 1'b0, acc);
    check("beq_alu", ALUctrl, 4'b0001);
    check("beq_imm", ImmOp, 32'hFFFFFFFC);
    check("beq_branch", branch, 1'b1);
    check("beq_pc", out_pc, 32'h100);
    cycle(1'b1, 32'hFFFFFFFF, 32'h104, 1'b1, 1'b0, acc);
    check("ill_flag", illegal, 1'b1);
    check("ill_rw", reg_write, 1'b0);
    check("ill_valid", out_valid, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // backpressure: A accepted, then 3 stalled cycles while B is offered
    bp_ins[0] = 32'h00500113;
    bp_ins[1] = 32'h00A00193;
    cycle(1'b1, bp_ins[0], 32'h200, 1'b0, 1'b0, acc);
    idx = 1;
    for (int c = 0; c < 3; c++) begin
      cycle(idx < 2, bp_ins[1], 32'h204, 1'b0, 1'b0, acc);
      if (acc) idx++;
      check("bp_hold_pc", out_pc, 32'h200);
    end
    for (int c = 0; c < 4; c++) begin
      cycle(idx < 2, bp_ins[1], 32'h204, 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_b_taken", idx, 2);

    // flush with a held bundle and a same-cycle acceptance
    cycle(1'b1, 32'h002081B3, 32'h300, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h402081B3, 32'h304, 1'b1, 1'b1, acc);
    check("flush_valid", out_valid, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, acc);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // asynchronous reset in the middle of a stall
    cycle(1'b1, 32'h00500113, 32'h400, 1'b0, 1'b0, acc);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_bundle", dut_b, '0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_in_ready", in_ready, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

    // random stream; an offered instruction is held until it is accepted
    cur_v = 1'b0; cur_i = '0; cur_pc = '0;
    for (int n = 0; n < 600; n++) begin
      if (!cur_v && $urandom_range(0, 9) < 7) begin
        cur_v  = 1'b1;
        cur_i  = gen_instr();
        cur_pc = $urandom;
      end
      cycle(cur_v, cur_i, cur_pc, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, acc);
      if (acc) cur_v = 1'b0;
    end
    for (int c = 0; c < 3; c++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
